int_mult_pipe: RTL and testbench

- Pipelined, parametrised integer multiplier for the shared APU cluster.
- Runs the same operator set as the combinational shared multiplier: 32-bit MAC/MSU and subword multiply with shift and optional rounding.
- Adds MUL_H (the upper word of the full product), a tagged valid/ready handshake, a configurable pipeline depth and a synchronous flush.
- Sits between the APU interconnect arbiter and the result write-back path.

---
 rtl/int_mult_pkg.sv | 19 +
 rtl/riscv_defines.sv | 12 +
 rtl/int_mult_core.sv | 60 ++++++
 rtl/int_mult_pipe.sv | 110 +++++++++++
 tb/tb_int_mult_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/int_mult_pkg.sv
// Shared constants and helpers for the pipelined integer multiplier.
package int_mult_pkg;
    import riscv_defines::*;

    localparam int unsigned INT_MULT_OP_W = 3;

    // Dot-product modes and code 3'b111 are carried through the pipe but not evaluated.
    function automatic logic int_mult_op_supported(input logic [INT_MULT_OP_W-1:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            MUL_MAC32, MUL_MSU32, MUL_I, MUL_IR, MUL_H: ok = 1'b1;
            MUL_DOT8, MUL_DOT16:                        ok = 1'b0;
            default:                                    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/riscv_defines.sv
// Multiplier operator codes shared by the core's MULT unit and the APU cluster.
package riscv_defines;

    localparam logic [2:0] MUL_MAC32 = 3'b000;
    localparam logic [2:0] MUL_MSU32 = 3'b001;
    localparam logic [2:0] MUL_I     = 3'b010;
    localparam logic [2:0] MUL_IR    = 3'b011;
    localparam logic [2:0] MUL_DOT8  = 3'b100;
    localparam logic [2:0] MUL_DOT16 = 3'b101;
    localparam logic [2:0] MUL_H     = 3'b110;

endpackage

// File: rtl/int_mult_core.sv
// Combinational operator evaluation: MAC/MSU, subword multiply with shift/round, upper product word.
module int_mult_core
    import riscv_defines::*;
    import int_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [INT_MULT_OP_W-1:0] operator_i,
    input  logic [WIDTH-1:0]         op_a_i,
    input  logic [WIDTH-1:0]         op_b_i,
    input  logic [WIDTH-1:0]         op_c_i,
    input  logic [$clog2(WIDTH)-1:0] imm_i,
    input  logic                     short_subword_i,
    input  logic [1:0]               short_signed_i,
    output logic [WIDTH-1:0]         result_c,
    output logic                     unsupported_c
);

    localparam int unsigned HALF  = WIDTH / 2;
    localparam int unsigned IMM_W = $clog2(WIDTH);

    logic [HALF-1:0]           half_a;
    logic [HALF-1:0]           half_b;
    logic [WIDTH-1:0]          short_a;
    logic [WIDTH-1:0]          short_b;
    logic [WIDTH-1:0]          short_round;
    logic [WIDTH-1:0]          short_mac;
    logic signed [WIDTH+1:0]   short_ext;
    logic [2*WIDTH-1:0]        full_a;
    logic [2*WIDTH-1:0]        full_b;

    // Subword path: only the low WIDTH bits of the mac matter, the top two are re-derived from bit WIDTH-1.
    always_comb begin
        half_a      = short_subword_i ? op_a_i[WIDTH-1:HALF] : op_a_i[HALF-1:0];
        half_b      = short_subword_i ? op_b_i[WIDTH-1:HALF] : op_b_i[HALF-1:0];
        short_a     = {{HALF{short_signed_i[0] & half_a[HALF-1]}}, half_a};
        short_b     = {{HALF{short_signed_i[1] & half_b[HALF-1]}}, half_b};
        short_round = '0;
        if (operator_i == MUL_IR && imm_i != '0) begin
            short_round = WIDTH'(1) << (imm_i - IMM_W'(1));
        end
        short_mac = op_c_i + short_a * short_b + short_round;
        short_ext = {{2{short_signed_i[0] & short_mac[WIDTH-1]}}, short_mac};
        full_a    = {{WIDTH{short_signed_i[0] & op_a_i[WIDTH-1]}}, op_a_i};
        full_b    = {{WIDTH{short_signed_i[1] & op_b_i[WIDTH-1]}}, op_b_i};
    end

    always_comb begin
        result_c      = '0;
        unsupported_c = !int_mult_op_supported(operator_i);
        case (operator_i)
            MUL_MAC32:    result_c = op_c_i + op_a_i * op_b_i;
            MUL_MSU32:    result_c = op_c_i - op_a_i * op_b_i;
            MUL_I, MUL_IR: result_c = WIDTH'(short_ext >>> imm_i);
            MUL_H:        result_c = WIDTH'((full_a * full_b) >> WIDTH);
            default:      result_c = '0;
        endcase
    end

endmodule

// File: rtl/int_mult_pipe.sv
// Elastic STAGES-deep pipeline around int_mult_core with tagged valid/ready and synchronous flush.
module int_mult_pipe
    import int_mult_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned STAGES    = 2,
    parameter int unsigned TAG_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [INT_MULT_OP_W-1:0] operator_i,
    input  logic [WIDTH-1:0]         op_a_i,
    input  logic [WIDTH-1:0]         op_b_i,
    input  logic [WIDTH-1:0]         op_c_i,
    input  logic [$clog2(WIDTH)-1:0] imm_i,
    input  logic                     short_subword_i,
    input  logic [1:0]               short_signed_i,
    input  logic [TAG_WIDTH-1:0]     tag_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [WIDTH-1:0]         result_o,
    output logic [TAG_WIDTH-1:0]     tag_o,
    output logic                     unsupported_o
);

    typedef struct packed {
        logic                 valid;
        logic [WIDTH-1:0]     result;
        logic [TAG_WIDTH-1:0] tag;
        logic                 unsupported;
    } int_mult_stage_t;

    int_mult_stage_t stage_q [STAGES];
    int_mult_stage_t stage_d [STAGES];
    logic [STAGES:0] ready_c;
    logic [WIDTH-1:0] core_result_c;
    logic             core_unsupported_c;

    int_mult_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .operator_i      (operator_i),
        .op_a_i          (op_a_i),
        .op_b_i          (op_b_i),
        .op_c_i          (op_c_i),
        .imm_i           (imm_i),
        .short_subword_i (short_subword_i),
        .short_signed_i  (short_signed_i),
        .result_c        (core_result_c),
        .unsupported_c   (core_unsupported_c)
    );

    // Ready ripples back from the consumer so a full pipe can accept and drain in the same cycle.
    always_comb begin
        ready_c[STAGES] = out_ready_i;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            ready_c[k] = !stage_q[k].valid | ready_c[k+1];
        end
    end

    always_comb begin
        for (int k = 0; k < int'(STAGES); k++) begin
            stage_d[k] = stage_q[k];
        end
        if (ready_c[0]) begin
            stage_d[0].valid = in_valid_i;
            if (in_valid_i) begin
                stage_d[0].result      = core_result_c;
                stage_d[0].tag         = tag_i;
                stage_d[0].unsupported = core_unsupported_c;
            end
        end
        for (int k = 1; k < int'(STAGES); k++) begin
            if (ready_c[k]) begin
                stage_d[k].valid = stage_q[k-1].valid;
                if (stage_q[k-1].valid) begin
                    stage_d[k] = stage_q[k-1];
                end
            end
        end
        // Flush wins over any accept or advance this cycle; payload is left as is.
        if (flush_i) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                stage_d[k].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign in_ready_o    = ready_c[0];
    assign out_valid_o   = stage_q[STAGES-1].valid;
    assign result_o      = stage_q[STAGES-1].result;
    assign tag_o         = stage_q[STAGES-1].tag;
    assign unsupported_o = stage_q[STAGES-1].unsupported;

endmodule

// File: tb/tb_int_mult_pipe.sv
// Self-checking bench for int_mult_pipe: directed operator vectors, back-pressure, flush, reset, random traffic.
module tb_int_mult_pipe;
    import riscv_defines::*;

    localparam int unsigned W  = 32;
    localparam int unsigned ST = 2;
    localparam int unsigned TW = 4;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    operator;
    logic [W-1:0]  op_a, op_b, op_c;
    logic [4:0]    imm;
    logic          subword;
    logic [1:0]    sgn;
    logic [TW-1:0] tag_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [TW-1:0] tag_out;
    logic          unsupported;

    int n_checks = 0;
    int n_pass   = 0;

    int_mult_pipe #(.WIDTH(W), .STAGES(ST), .TAG_WIDTH(TW)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .operator_i      (operator),
        .op_a_i          (op_a),
        .op_b_i          (op_b),
        .op_c_i          (op_c),
        .imm_i           (imm),
        .short_subword_i (subword),
        .short_signed_i  (sgn),
        .tag_i           (tag_in),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .result_o        (result),
        .tag_o           (tag_out),
        .unsupported_o   (unsupported)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer arithmetic on interpreted operand values; returns {unsupported, result}.
    function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [4:0] sh, input logic sub,
                                          input logic [1:0] sg);
        longint va, vb, m, v;
        logic [15:0] ha, hb;
        logic [31:0] low;
        logic [63:0] p;
        case (op)
            3'd0: return {1'b0, 32'(longint'(c) + longint'(a) * longint'(b))};
            3'd1: return {1'b0, 32'(longint'(c) - longint'(a) * longint'(b))};
            3'd2, 3'd3: begin
                ha = sub ? a[31:16] : a[15:0];
                hb = sub ? b[31:16] : b[15:0];
                va = sg[0] ? longint'($signed(ha)) : longint'(ha);
                vb = sg[1] ? longint'($signed(hb)) : longint'(hb);
                m  = longint'(c) + va * vb;
                if (op == 3'd3 && sh != 0) m = m + (longint'(1) << (sh - 1));
                low = m[31:0];
                v   = sg[0] ? longint'($signed(low)) : longint'(low);
                v   = v >>> sh;
                return {1'b0, v[31:0]};
            end
            3'd6: begin
                va = sg[0] ? longint'($signed(a)) : longint'(a);
                vb = sg[1] ? longint'($signed(b)) : longint'(b);
                p  = 64'(va * vb);
                return {1'b0, p[63:32]};
            end
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    task automatic idle();
        flush = 1'b0; in_valid = 1'b0; operator = MUL_MAC32;
        op_a = '0; op_b = '0; op_c = '0; imm = '0; subword = 1'b0; sgn = 2'b00; tag_in = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [4:0] sh, input logic sub, input logic [1:0] sg, input logic [3:0] t);
        in_valid = 1'b1; operator = op; op_a = a; op_b = b; op_c = c;
        imm = sh; subword = sub; sgn = sg; tag_in = t;
    endtask

    task automatic test_reset();
        idle();
        out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (result !== '0) $display("FAIL reset_result got %h want 0", result); else n_pass++;
        n_checks++; if (tag_out !== '0) $display("FAIL reset_tag got %h want 0", tag_out); else n_pass++;
        n_checks++; if (unsupported !== 1'b0) $display("FAIL reset_unsupported got %b want 0", unsupported); else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    endtask

    // One op into an empty pipe with out_ready=1; result must appear exactly two cycles after accept.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [4:0] sh, input logic sub, input logic [1:0] sg,
                          input logic [3:0] t, input logic [31:0] exp_res, input logic exp_uns);
        out_ready = 1'b1;
        drive(op, a, b, c, sh, sub, sg, t);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL %s_in_ready got %b want 1", name, in_ready); else n_pass++;
        tick();
        idle();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL %s_early_valid got %b want 0", name, out_valid); else n_pass++;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || result !== exp_res || tag_out !== t || unsupported !== exp_uns)
            $display("FAIL %s got v=%b res=%h tag=%h uns=%b want v=1 res=%h tag=%h uns=%b",
                     name, out_valid, result, tag_out, unsupported, exp_res, t, exp_uns);
        else n_pass++;
        tick();
    endtask

    task automatic test_operators();
        run_op("mac",      MUL_MAC32, 32'd3, 32'd5, 32'd10, 5'd0, 1'b0, 2'b00, 4'd1, 32'h0000_0019, 1'b0);
        run_op("msu",      MUL_MSU32, 32'd3, 32'd5, 32'd10, 5'd0, 1'b0, 2'b00, 4'd2, 32'hFFFF_FFFB, 1'b0);
        run_op("ir_round", MUL_IR, 32'd7, 32'd3, 32'd0, 5'd2, 1'b0, 2'b11, 4'd3, 32'h0000_0005, 1'b0);
        run_op("i_signed", MUL_I, 32'hFFFF_FFFE, 32'd3, 32'd0, 5'd1, 1'b0, 2'b11, 4'd4, 32'hFFFF_FFFD, 1'b0);
        run_op("i_subword", MUL_I, 32'h0004_0000, 32'h0002_0000, 32'd0, 5'd0, 1'b1, 2'b00, 4'd5,
               32'h0000_0008, 1'b0);
        run_op("h_signed", MUL_H, 32'h8000_0000, 32'd2, 32'd0, 5'd0, 1'b0, 2'b11, 4'd6, 32'hFFFF_FFFF, 1'b0);
        run_op("h_unsigned", MUL_H, 32'h8000_0000, 32'd2, 32'd0, 5'd0, 1'b0, 2'b00, 4'd7, 32'h0000_0001, 1'b0);
        run_op("dot8_unsup", 3'b100, 32'h1234_5678, 32'd9, 32'd1, 5'd0, 1'b0, 2'b00, 4'd8, 32'h0, 1'b1);
        run_op("op7_unsup", 3'b111, 32'h1234_5678, 32'd9, 32'd1, 5'd0, 1'b0, 2'b00, 4'd9, 32'h0, 1'b1);
    endtask

    task automatic test_back_pressure();
        int next_tag;
        logic held;
        logic [31:0] held_res;
        logic [3:0] held_tag;
        logic [3:0] got[$];
        int got_cyc[$];
        next_tag = 1;
        held = 1'b0;
        held_res = '0;
        held_tag = '0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            out_ready = (cyc >= 4);
            if (next_tag <= 3) drive(MUL_MAC32, 32'(next_tag), 32'd9, 32'd1, 5'd0, 1'b0, 2'b00, 4'(next_tag));
            else idle();
            @(negedge clk);
            if (cyc == 2 || cyc == 3) begin
                n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_c%0d got %b want 0", cyc, in_ready); else n_pass++;
                n_checks++; if (next_tag != 3) $display("FAIL bp_accepts_c%0d got %0d want 2", cyc, next_tag - 1); else n_pass++;
            end
            if (held) begin
                n_checks++;
                if (out_valid !== 1'b1 || result !== held_res || tag_out !== held_tag)
                    $display("FAIL bp_stable got v=%b res=%h tag=%h want v=1 res=%h tag=%h",
                             out_valid, result, tag_out, held_res, held_tag);
                else n_pass++;
            end
            held = out_valid && !out_ready;
            held_res = result;
            held_tag = tag_out;
            if (out_valid && out_ready) begin
                got.push_back(tag_out);
                got_cyc.push_back(cyc);
                n_checks++;
                if (result !== 32'(9 * int'(tag_out) + 1))
                    $display("FAIL bp_result got %h want %h", result, 32'(9 * int'(tag_out) + 1));
                else n_pass++;
            end
            if (in_valid && in_ready) next_tag++;
            tick();
        end
        idle();
        n_checks++; if (got.size() != 3) $display("FAIL bp_count got %0d want 3", got.size()); else n_pass++;
        for (int i = 0; i < got.size() && i < 3; i++) begin
            n_checks++;
            if (got[i] !== 4'(i + 1) || got_cyc[i] != 4 + i)
                $display("FAIL bp_order%0d got tag=%0d cyc=%0d want tag=%0d cyc=%0d", i, got[i], got_cyc[i], i + 1, 4 + i);
            else n_pass++;
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(MUL_MAC32, 32'd2, 32'd2, 32'd0, 5'd0, 1'b0, 2'b00, 4'd5);
        tick();
        drive(MUL_MAC32, 32'd3, 32'd3, 32'd0, 5'd0, 1'b0, 2'b00, 4'd6);
        tick();
        drive(MUL_MAC32, 32'd4, 32'd4, 32'd0, 5'd0, 1'b0, 2'b00, 4'd7);
        flush = 1'b1;
        tick();
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_full_c%0d got valid %b want 0", i, out_valid); else n_pass++;
        end
        tick();
        // Empty pipe: the op would be accepted, but flush must drop it.
        drive(MUL_MAC32, 32'd5, 32'd5, 32'd0, 5'd0, 1'b0, 2'b00, 4'd8);
        flush = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready got %b want 1", in_ready); else n_pass++;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_accept_c%0d got valid %b want 0", i, out_valid); else n_pass++;
        end
        tick();
        run_op("after_flush", MUL_MAC32, 32'd6, 32'd7, 32'd1, 5'd0, 1'b0, 2'b00, 4'd9, 32'd43, 1'b0);
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(MUL_MAC32, 32'd11, 32'd13, 32'd0, 5'd0, 1'b0, 2'b00, 4'hA);
        tick();
        drive(MUL_MAC32, 32'd17, 32'd19, 32'd0, 5'd0, 1'b0, 2'b00, 4'hB);
        tick();
        idle();
        n_checks++;
        if (out_valid !== 1'b1 || result !== 32'd143 || tag_out !== 4'hA)
            $display("FAIL ar_stalled got v=%b res=%h tag=%h want v=1 res=0000008f tag=a", out_valid, result, tag_out);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL ar_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (result !== '0) $display("FAIL ar_result got %h want 0", result); else n_pass++;
        n_checks++; if (tag_out !== '0) $display("FAIL ar_tag got %h want 0", tag_out); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        n_checks++; if (in_ready !== 1'b1) $display("FAIL ar_in_ready got %b want 1", in_ready); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) $display("FAIL ar_replay_c%0d got valid %b want 0", i, out_valid); else n_pass++;
        end
        tick();
    endtask

    task automatic test_random();
        logic [32:0] exp_q[$];
        logic [3:0]  tag_q[$];
        logic [32:0] e;
        logic [3:0]  et;
        logic held;
        logic [36:0] held_pay;
        logic [31:0] a, b;
        held = 1'b0;
        held_pay = '0;
        for (int cyc = 0; cyc < 420; cyc++) begin
            if (cyc < 400) begin
                a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
                b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
                drive(3'($urandom), a, b, 32'($urandom), 5'($urandom), 1'($urandom), 2'($urandom), 4'($urandom));
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                idle();
                out_ready = 1'b1;
            end
            @(negedge clk);
            if (held) begin
                n_checks++;
                if (out_valid !== 1'b1 || {unsupported, result, tag_out} !== held_pay)
                    $display("FAIL rnd_stable c%0d got v=%b pay=%h want v=1 pay=%h", cyc, out_valid,
                             {unsupported, result, tag_out}, held_pay);
                else n_pass++;
            end
            held = out_valid && !out_ready;
            held_pay = {unsupported, result, tag_out};
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rnd_extra c%0d got tag=%h with nothing outstanding", cyc, tag_out);
                end else begin
                    e = exp_q.pop_front();
                    et = tag_q.pop_front();
                    if ({unsupported, result, tag_out} !== {e, et})
                        $display("FAIL rnd_result c%0d got uns=%b res=%h tag=%h want uns=%b res=%h tag=%h",
                                 cyc, unsupported, result, tag_out, e[32], e[31:0], et);
                    else n_pass++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(operator, op_a, op_b, op_c, imm, subword, sgn));
                tag_q.push_back(tag_in);
            end
            tick();
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL rnd_drain got %0d outstanding want 0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        idle();
        out_ready = 1'b1;
        rst = 1'b1;
        test_reset();
        test_operators();
        test_back_pressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
